// File: rtl/mod_99_6_rx_merge.sv
// mod_99_6_rx_merge: MAC Merge receive path, splits express/preemptable traffic and reassembles pMAC fragments
module mod_99_6_rx_merge #(
  parameter int MIN_PREAMBLE = 5
) (
  input  logic       clk,
  input  logic       reset_begin,
  input  logic       rx_dv,
  input  logic [7:0] rx_data,
  input  logic       rx_er,
  output logic       e_valid,
  output logic       e_sof,
  output logic       e_eof,
  output logic       e_err,
  output logic [7:0] e_data,
  output logic       p_valid,
  output logic       p_sof,
  output logic       p_eof,
  output logic       p_err,
  output logic [7:0] p_data,
  output logic       verify_rcv,
  output logic       respond_rcv,
  output logic       p_active,
  output logic [3:0] rx_state
);
  typedef enum logic [3:0] {
    IDLE, PREAMBLE, EXPRESS, P_DATA, P_FLUSH, FRAG_COUNT, VERIFY, RESPOND, DISCARD
  } state_t;
  localparam logic [2:0] MINP = 3'(MIN_PREAMBLE);
  function automatic logic [2:0] dec_s(input logic [7:0] b);
    return b == 8'hE6 ? 3'b100 : b == 8'h4C ? 3'b101 : b == 8'h7F ? 3'b110 : b == 8'hB3 ? 3'b111 : 3'b000;
  endfunction
  function automatic logic [2:0] dec_c(input logic [7:0] b);
    return b == 8'h61 ? 3'b100 : b == 8'h52 ? 3'b101 : b == 8'h9E ? 3'b110 : b == 8'h2A ? 3'b111 : 3'b000;
  endfunction
  function automatic logic [7:0] frag_code(input logic [1:0] n);
    return n == 2'd0 ? 8'hE6 : n == 2'd1 ? 8'h4C : n == 2'd2 ? 8'h7F : 8'hB3;
  endfunction
  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c;
    for (int i = 0; i < 8; i++) x = (x >> 1) ^ ((x[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return x;
  endfunction
  state_t      r_state, w_state;
  logic [2:0]  r_pre_cnt, w_pre_cnt, r_hcnt, w_hcnt;
  logic [1:0]  r_p_frame, w_p_frame, r_exp_frag, w_exp_frag, r_fcnt, w_fcnt;
  logic [31:0] r_crc, w_crc, r_hold, w_hold;
  logic        r_p_active, w_p_active, r_psof, w_psof;
  logic [7:0]  r_e_byte, w_e_byte;
  logic        r_e_full, w_e_full, r_e_first, w_e_first;
  logic        w_ev, w_esof, w_eeof, w_eerr, w_pv, w_psof_o, w_peof, w_perr, w_vr, w_rr;
  logic [7:0]  w_edata, w_pdata;
  logic        w_pop, w_pabort;
  state_t      w_done;
  logic [2:0]  w_s, w_c;
  logic [31:0] w_fcs, w_crc_pop;
  assign w_s       = dec_s(rx_data);
  assign w_c       = dec_c(rx_data);
  assign w_fcs     = ~r_crc;
  assign w_crc_pop = crc8(r_crc, r_hold[7:0]);
  assign w_done    = rx_dv ? DISCARD : IDLE;
  assign p_active  = r_p_active;
  assign rx_state  = r_state;
  // next-state, datapath updates and output strobes
  always_comb begin
    w_state = r_state;
    w_pre_cnt = r_pre_cnt;
    w_p_frame = r_p_frame;
    w_exp_frag = r_exp_frag;
    w_crc = r_crc;
    w_hold = r_hold;
    w_hcnt = r_hcnt;
    w_fcnt = r_fcnt;
    w_p_active = r_p_active;
    w_psof = r_psof;
    w_e_byte = r_e_byte;
    w_e_full = r_e_full;
    w_e_first = r_e_first;
    {w_ev, w_esof, w_eeof, w_eerr} = 4'b0;
    w_edata = 8'h00;
    {w_pv, w_psof_o, w_peof, w_perr} = 4'b0;
    w_pdata = 8'h00;
    w_vr = 1'b0;
    w_rr = 1'b0;
    w_pop = 1'b0;
    w_pabort = 1'b0;
    case (r_state)
      IDLE: if (rx_dv) begin
        w_state = (rx_data == 8'h55 && !rx_er) ? PREAMBLE : DISCARD;
        w_pre_cnt = 3'd1;
      end
      PREAMBLE: if (!rx_dv) w_state = IDLE;
      else if (rx_er) w_state = DISCARD;
      else if (rx_data == 8'h55) w_pre_cnt = r_pre_cnt == 3'd7 ? 3'd7 : r_pre_cnt + 3'd1;
      else if (r_pre_cnt < MINP) w_state = DISCARD;
      else if (rx_data == 8'hD5) begin
        w_state = EXPRESS;
        w_e_first = 1'b1;
        w_e_full = 1'b0;
      end
      else if (rx_data == 8'h07) w_state = VERIFY;
      else if (rx_data == 8'h19) w_state = RESPOND;
      else if (w_s[2]) begin
        {w_pv, w_peof, w_perr} = {3{r_p_active}};
        w_p_frame = w_s[1:0];
        w_exp_frag = 2'd0;
        w_crc = '1;
        w_p_active = 1'b1;
        w_psof = 1'b1;
        w_hcnt = 3'd0;
        w_state = P_DATA;
      end
      else if (w_c[2] && r_p_active && w_c[1:0] == r_p_frame) w_state = FRAG_COUNT;
      else begin
        w_pabort = w_c[2];
        w_state = DISCARD;
      end
      FRAG_COUNT: if (rx_dv && !rx_er && rx_data == frag_code(r_exp_frag)) begin
        w_exp_frag = r_exp_frag + 2'd1;
        w_hcnt = 3'd0;
        w_state = P_DATA;
      end else begin
        w_pabort = 1'b1;
        w_state = w_done;
      end
      EXPRESS: if (!rx_dv) begin
        {w_ev, w_eeof} = {2{r_e_full}};
        w_esof = r_e_full & r_e_first;
        w_edata = r_e_full ? r_e_byte : 8'h00;
        w_state = IDLE;
      end else if (rx_er) begin
        {w_ev, w_eeof, w_eerr} = 3'b111;
        w_state = DISCARD;
      end else begin
        w_e_byte = rx_data;
        w_e_full = 1'b1;
        w_ev = r_e_full;
        w_esof = r_e_full & r_e_first;
        w_edata = r_e_full ? r_e_byte : 8'h00;
        w_e_first = r_e_first & ~r_e_full;
      end
      P_DATA: if (!rx_dv) begin
        w_state = P_FLUSH;
        w_fcnt = 2'd0;
      end else if (rx_er) begin
        w_pabort = 1'b1;
        w_state = DISCARD;
      end else begin
        w_hold = {rx_data, r_hold[31:8]};
        w_pop = r_hcnt == 3'd4;
        w_hcnt = r_hcnt == 3'd4 ? r_hcnt : r_hcnt + 3'd1;
      end
      P_FLUSH: if (r_fcnt == 2'd0 && r_hcnt != 3'd4) begin
        w_pabort = 1'b1;
        w_state = w_done;
      end else if (r_fcnt == 2'd0 && r_hold == (w_fcs ^ 32'hFFFF0000)) w_state = w_done;
      else begin
        w_pop = 1'b1;
        w_hold = {8'h00, r_hold[31:8]};
        w_fcnt = r_fcnt + 2'd1;
        if (r_fcnt == 2'd3) begin
          w_peof = 1'b1;
          w_p_active = 1'b0;
          w_state = w_done;
        end
      end
      VERIFY, RESPOND: if (!rx_dv) begin
        w_vr = r_state == VERIFY;
        w_rr = r_state == RESPOND;
        w_state = IDLE;
      end else if (rx_er) w_state = DISCARD;
      default: if (!rx_dv) w_state = IDLE;
    endcase
    if (w_pop) begin
      w_pv = 1'b1;
      w_pdata = r_hold[7:0];
      w_psof_o = r_psof;
      w_psof = 1'b0;
      w_crc = w_crc_pop;
    end
    if (w_pabort) begin
      {w_pv, w_peof, w_perr} = {3{r_p_active}};
      w_p_active = 1'b0;
    end
  end
  // state register
  always_ff @(posedge clk or posedge reset_begin)
    if (reset_begin) r_state <= IDLE;
    else r_state <= w_state;
  // datapath registers and registered outputs
  always_ff @(posedge clk or posedge reset_begin)
    if (reset_begin) begin
      r_pre_cnt <= 3'd0;
      r_p_frame <= 2'd0;
      r_exp_frag <= 2'd0;
      r_crc <= 32'hFFFFFFFF;
      r_hold <= 32'h0;
      r_hcnt <= 3'd0;
      r_fcnt <= 2'd0;
      r_p_active <= 1'b0;
      r_psof <= 1'b0;
      r_e_byte <= 8'h00;
      r_e_full <= 1'b0;
      r_e_first <= 1'b0;
      {e_valid, e_sof, e_eof, e_err} <= 4'b0;
      e_data <= 8'h00;
      {p_valid, p_sof, p_eof, p_err} <= 4'b0;
      p_data <= 8'h00;
      verify_rcv <= 1'b0;
      respond_rcv <= 1'b0;
    end else begin
      r_pre_cnt <= w_pre_cnt;
      r_p_frame <= w_p_frame;
      r_exp_frag <= w_exp_frag;
      r_crc <= w_crc;
      r_hold <= w_hold;
      r_hcnt <= w_hcnt;
      r_fcnt <= w_fcnt;
      r_p_active <= w_p_active;
      r_psof <= w_psof;
      r_e_byte <= w_e_byte;
      r_e_full <= w_e_full;
      r_e_first <= w_e_first;
      {e_valid, e_sof, e_eof, e_err} <= {w_ev, w_esof, w_eeof, w_eerr};
      e_data <= w_edata;
      {p_valid, p_sof, p_eof, p_err} <= {w_pv, w_psof_o, w_peof, w_perr};
      p_data <= w_pdata;
      verify_rcv <= w_vr;
      respond_rcv <= w_rr;
    end
endmodule

// File: tb/tb_mod_99_6_rx_merge.sv
// tb_mod_99_6_rx_merge: scoreboard bench for the MAC Merge receive path
module tb_mod_99_6_rx_merge;
  logic clk = 1'b0, reset_begin = 1'b1, rx_dv = 1'b0, rx_er = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic e_valid, e_sof, e_eof, e_err, p_valid, p_sof, p_eof, p_err;
  logic [7:0] e_data, p_data;
  logic verify_rcv, respond_rcv, p_active;
  logic [3:0] rx_state;
  int n_pass = 0, n_total = 0, v_cnt = 0, r_cnt = 0;
  logic [10:0] exp_e[$], exp_p[$];

  mod_99_6_rx_merge #(.MIN_PREAMBLE(5)) dut (
    .clk(clk), .reset_begin(reset_begin), .rx_dv(rx_dv), .rx_data(rx_data), .rx_er(rx_er),
    .e_valid(e_valid), .e_sof(e_sof), .e_eof(e_eof), .e_err(e_err), .e_data(e_data),
    .p_valid(p_valid), .p_sof(p_sof), .p_eof(p_eof), .p_err(p_err), .p_data(p_data),
    .verify_rcv(verify_rcv), .respond_rcv(respond_rcv), .p_active(p_active), .rx_state(rx_state)
  );

  always #5 clk = ~clk;

  // scoreboard: every output beat must match the head of its expected queue
  always @(negedge clk) if (!reset_begin) begin
    if (e_valid) begin
      n_total++;
      if (exp_e.size() == 0) $display("FAIL e_beat: got unexpected %h", {e_sof, e_eof, e_err, e_data});
      else begin
        logic [10:0] x;
        x = exp_e.pop_front();
        if ({e_sof, e_eof, e_err, e_data} !== x) $display("FAIL e_beat: got %h want %h", {e_sof, e_eof, e_err, e_data}, x);
        else n_pass++;
      end
    end
    if (p_valid) begin
      n_total++;
      if (exp_p.size() == 0) $display("FAIL p_beat: got unexpected %h", {p_sof, p_eof, p_err, p_data});
      else begin
        logic [10:0] y;
        y = exp_p.pop_front();
        if ({p_sof, p_eof, p_err, p_data} !== y) $display("FAIL p_beat: got %h want %h", {p_sof, p_eof, p_err, p_data}, y);
        else n_pass++;
      end
    end
    if (verify_rcv) v_cnt++;
    if (respond_rcv) r_cnt++;
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'h0, d};
    repeat (8) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction

  task automatic send(input logic [7:0] b, input logic er = 1'b0);
    @(posedge clk);
    #1 rx_dv = 1'b1;
    rx_data = b;
    rx_er = er;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 rx_dv = 1'b0;
      rx_er = 1'b0;
      rx_data = 8'h00;
    end
  endtask

  task automatic pre(input int n);
    repeat (n) send(8'h55);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++;
    if ({e_valid, e_sof, e_eof, e_err, e_data, p_valid, p_sof, p_eof, p_err, p_data, verify_rcv, respond_rcv, p_active} !== 25'h0)
      $display("FAIL reset_outputs: got nonzero outputs, want 0");
    else n_pass++;
    n_total++;
    if (rx_state !== 4'd0) $display("FAIL reset_state: got %0d want 0", rx_state);
    else n_pass++;
    @(posedge clk);
    #1 reset_begin = 1'b0;
    idle(2);
  endtask

  task automatic test_express();
    for (int i = 0; i < 64; i++) exp_e.push_back({i == 0, i == 63, 1'b0, 8'(i)});
    pre(7);
    send(8'hD5);
    for (int i = 0; i < 64; i++) send(8'(i));
    idle(8);
    n_total++;
    if (exp_e.size() !== 0) $display("FAIL express_left: got %0d beats missing, want 0", exp_e.size());
    else n_pass++;
    n_total++;
    if (p_active !== 1'b0) $display("FAIL express_p_active: got %b want 0", p_active);
    else n_pass++;
  endtask

  task automatic test_preempt_single();
    logic [7:0] d [60];
    logic [31:0] c;
    c = '1;
    for (int i = 0; i < 60; i++) begin
      d[i] = 8'($urandom);
      c = crc_upd(c, d[i]);
      exp_p.push_back({i == 0, 1'b0, 1'b0, d[i]});
    end
    c = ~c;
    for (int i = 0; i < 4; i++) exp_p.push_back({1'b0, i == 3, 1'b0, c[8*i +: 8]});
    pre(7);
    send(8'hE6);
    for (int i = 0; i < 60; i++) begin
      send(d[i]);
      if (i == 10) begin
        @(negedge clk);
        n_total++;
        if (p_active !== 1'b1) $display("FAIL single_active: got %b want 1", p_active);
        else n_pass++;
      end
    end
    send_word(c);
    idle(8);
    n_total++;
    if (exp_p.size() !== 0) $display("FAIL single_left: got %0d beats missing, want 0", exp_p.size());
    else n_pass++;
    n_total++;
    if (p_active !== 1'b0) $display("FAIL single_inactive: got %b want 0", p_active);
    else n_pass++;
  endtask

  task automatic test_fragmented();
    logic [7:0] d [100];
    logic [31:0] c, m;
    c = '1;
    for (int i = 0; i < 100; i++) begin
      d[i] = 8'($urandom);
      exp_p.push_back({i == 0, 1'b0, 1'b0, d[i]});
    end
    for (int i = 0; i < 60; i++) c = crc_upd(c, d[i]);
    m = ~c ^ 32'hFFFF0000;
    for (int i = 60; i < 100; i++) c = crc_upd(c, d[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) exp_p.push_back({1'b0, i == 3, 1'b0, c[8*i +: 8]});
    pre(7);
    send(8'hE6);
    for (int i = 0; i < 60; i++) send(d[i]);
    send_word(m);
    idle(8);
    n_total++;
    if (exp_p.size() !== 44) $display("FAIL frag1_left: got %0d beats pending, want 44", exp_p.size());
    else n_pass++;
    n_total++;
    if (p_active !== 1'b1) $display("FAIL frag1_active: got %b want 1", p_active);
    else n_pass++;
    for (int i = 0; i < 20; i++) exp_e.push_back({i == 0, i == 19, 1'b0, 8'(i + 8'hA0)});
    pre(6);
    send(8'hD5);
    for (int i = 0; i < 20; i++) send(8'(i + 8'hA0));
    idle(8);
    n_total++;
    if (exp_e.size() !== 0) $display("FAIL frag_express_left: got %0d missing, want 0", exp_e.size());
    else n_pass++;
    n_total++;
    if (p_active !== 1'b1) $display("FAIL frag_express_active: got %b want 1", p_active);
    else n_pass++;
    pre(6);
    send(8'h61);
    send(8'hE6);
    for (int i = 60; i < 100; i++) send(d[i]);
    send_word(c);
    idle(8);
    n_total++;
    if (exp_p.size() !== 0) $display("FAIL frag2_left: got %0d missing, want 0", exp_p.size());
    else n_pass++;
    n_total++;
    if (p_active !== 1'b0) $display("FAIL frag2_inactive: got %b want 0", p_active);
    else n_pass++;
  endtask

  task automatic send_nonfinal(input logic [7:0] smd);
    logic [7:0] d [20];
    logic [31:0] c;
    c = '1;
    for (int i = 0; i < 20; i++) begin
      d[i] = 8'($urandom);
      c = crc_upd(c, d[i]);
      exp_p.push_back({i == 0, 1'b0, 1'b0, d[i]});
    end
    pre(7);
    send(smd);
    for (int i = 0; i < 20; i++) send(d[i]);
    send_word(~c ^ 32'hFFFF0000);
    idle(8);
  endtask

  task automatic test_bad_continuation();
    send_nonfinal(8'hE6);
    exp_p.push_back({1'b0, 1'b1, 1'b1, 8'h00});
    pre(6);
    send(8'h52);
    for (int i = 0; i < 10; i++) send(8'($urandom));
    idle(8);
    n_total++;
    if (exp_p.size() !== 0) $display("FAIL badframe_left: got %0d missing, want 0", exp_p.size());
    else n_pass++;
    n_total++;
    if (p_active !== 1'b0) $display("FAIL badframe_inactive: got %b want 0", p_active);
    else n_pass++;
    send_nonfinal(8'h4C);
    n_total++;
    if (p_active !== 1'b1) $display("FAIL badfrag_active: got %b want 1", p_active);
    else n_pass++;
    exp_p.push_back({1'b0, 1'b1, 1'b1, 8'h00});
    pre(6);
    send(8'h52);
    send(8'h4C);
    for (int i = 0; i < 10; i++) send(8'($urandom));
    idle(8);
    n_total++;
    if (exp_p.size() !== 0) $display("FAIL badfrag_left: got %0d missing, want 0", exp_p.size());
    else n_pass++;
    n_total++;
    if (p_active !== 1'b0) $display("FAIL badfrag_inactive: got %b want 0", p_active);
    else n_pass++;
  endtask

  task automatic test_verify_respond();
    pre(7);
    send(8'h07);
    for (int i = 0; i < 60; i++) send(8'h00);
    send_word(32'h1234ABCD);
    idle(8);
    n_total++;
    if (v_cnt !== 1) $display("FAIL verify_pulse: got %0d cycles want 1", v_cnt);
    else n_pass++;
    pre(7);
    send(8'h07);
    for (int i = 0; i < 60; i++) send(8'h00, i == 30);
    idle(8);
    n_total++;
    if (v_cnt !== 1) $display("FAIL verify_err: got %0d cycles want 1", v_cnt);
    else n_pass++;
    pre(7);
    send(8'h19);
    for (int i = 0; i < 10; i++) send(8'h00);
    idle(8);
    n_total++;
    if (r_cnt !== 1 || v_cnt !== 1) $display("FAIL respond_pulse: got r=%0d v=%0d want r=1 v=1", r_cnt, v_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] d [20];
    for (int i = 0; i < 20; i++) begin
      d[i] = 8'($urandom);
      if (i < 15) exp_p.push_back({i == 0, 1'b0, 1'b0, d[i]});
    end
    pre(7);
    send(8'h7F);
    for (int i = 0; i < 20; i++) send(d[i]);
    @(posedge clk);
    #1 reset_begin = 1'b1;
    rx_dv = 1'b0;
    #1;
    n_total++;
    if ({e_valid, e_eof, p_valid, p_eof, p_err, p_data, verify_rcv, respond_rcv, p_active, rx_state} !== 20'h0)
      $display("FAIL midreset_outputs: got p_valid=%b p_eof=%b p_active=%b state=%0d want all 0", p_valid, p_eof, p_active, rx_state);
    else n_pass++;
    n_total++;
    if (exp_p.size() !== 0) $display("FAIL midreset_beats: got %0d missing, want 0", exp_p.size());
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 reset_begin = 1'b0;
    idle(4);
    for (int i = 0; i < 16; i++) exp_e.push_back({i == 0, i == 15, 1'b0, 8'(8'h30 + i)});
    pre(7);
    send(8'hD5);
    for (int i = 0; i < 16; i++) send(8'(8'h30 + i));
    idle(8);
    n_total++;
    if (exp_e.size() !== 0) $display("FAIL postreset_express: got %0d missing, want 0", exp_e.size());
    else n_pass++;
    n_total++;
    if (p_active !== 1'b0) $display("FAIL postreset_p_active: got %b want 0", p_active);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_express();
    test_preempt_single();
    test_fragmented();
    test_bad_continuation();
    test_verify_respond();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
